// File: rtl/mcu_window_sequencer_if.sv
// Row-in / column-out / result-out bus of the MCU window sequencer.
// slave is the sequencer's view, master the row memory / conv array / sink view.
interface mcu_window_sequencer_if #(
   parameter int N           = 4,
   parameter int K           = 3,
   parameter int BITS_IMAGEN = 8,
   parameter int BITS_DATA   = 13
);
   localparam int COL_W = (K > 1) ? $clog2(K) : 1;

   logic                              i_clear;
   logic [(N+K-1)*BITS_IMAGEN-1:0]    i_row;
   logic                              i_row_valid;
   logic                              o_row_ready;
   logic [K*N*BITS_IMAGEN-1:0]        o_DataConv;
   logic                              o_conv_valid;
   logic [COL_W-1:0]                  o_conv_col;
   logic [N*BITS_DATA-1:0]            i_DataConv;
   logic                              i_conv_done;
   logic [BITS_DATA-1:0]              o_Data;
   logic                              o_valid;
   logic                              i_ready;

   modport slave (
      input  i_clear, i_row, i_row_valid, i_DataConv, i_conv_done, i_ready,
      output o_row_ready, o_DataConv, o_conv_valid, o_conv_col, o_Data, o_valid
   );

   modport master (
      output i_clear, i_row, i_row_valid, i_DataConv, i_conv_done, i_ready,
      input  o_row_ready, o_DataConv, o_conv_valid, o_conv_col, o_Data, o_valid
   );
endinterface

// File: rtl/mcu_window_sequencer.sv
// Sliding K-row window feeding N conv units one column per cycle, then
// serialising the N results onto a valid/ready stream.
module mcu_wseq_lane #(
   parameter int J     = 0,
   parameter int K     = 3,
   parameter int NPIX  = 6,
   parameter int BI    = 8,
   parameter int COL_W = 2
) (
   input  logic [K-1:0][NPIX*BI-1:0] i_rows,
   input  logic [COL_W-1:0]          i_col,
   input  logic                      i_en,
   output logic [K-1:0][BI-1:0]      o_col
);
   always_comb begin
      o_col = '0;
      if (i_en) begin
         for (int r = 0; r < K; r++)
            o_col[r] = i_rows[r][(J + int'(i_col))*BI +: BI];
      end
   end
endmodule

module mcu_window_sequencer #(
   parameter int N           = 4,
   parameter int K           = 3,
   parameter int BITS_IMAGEN = 8,
   parameter int BITS_DATA   = 13
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   mcu_window_sequencer_if.slave bus
);
   localparam int NPIX  = N + K - 1;
   localparam int COL_W = (K > 1) ? $clog2(K) : 1;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int CNT_W = $clog2(K + 1);

   typedef enum logic [2:0] {S_FILL, S_CONV, S_WAIT, S_DRAIN, S_ACCEPT} state_t;

   state_t                                r_state, w_next;
   logic [K-1:0][NPIX*BITS_IMAGEN-1:0]    r_rows;
   logic [CNT_W-1:0]                      r_cnt;
   logic [COL_W-1:0]                      r_col;
   logic [IDX_W-1:0]                      r_idx;
   logic [N-1:0][BITS_DATA-1:0]           r_res;
   logic                                  w_accept;
   logic                                  w_conv;
   logic                                  w_last_col;
   logic                                  w_last_idx;
   logic [N-1:0][K-1:0][BITS_IMAGEN-1:0]  w_cols;

   assign w_conv      = (r_state == S_CONV);
   assign w_last_col  = (r_col == COL_W'(K-1));
   assign w_last_idx  = (r_idx == IDX_W'(N-1));
   assign bus.o_row_ready  = ((r_state == S_FILL) || (r_state == S_ACCEPT)) && !bus.i_clear;
   assign w_accept         = bus.o_row_ready && bus.i_row_valid;
   assign bus.o_conv_valid = w_conv;
   assign bus.o_conv_col   = r_col;
   assign bus.o_valid      = (r_state == S_DRAIN);
   assign bus.o_Data       = (r_state == S_DRAIN) ? r_res[r_idx] : '0;
   assign bus.o_DataConv   = w_cols;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) r_state <= S_FILL;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FILL:   if (w_accept && (r_cnt == CNT_W'(K-1))) w_next = S_CONV;
         S_CONV:   if (w_last_col) w_next = S_WAIT;
         S_WAIT:   if (bus.i_conv_done) w_next = S_DRAIN;
         S_DRAIN:  if (bus.i_ready && w_last_idx) w_next = S_ACCEPT;
         S_ACCEPT: if (w_accept) w_next = S_CONV;
         default:  w_next = S_FILL;
      endcase
      if (bus.i_clear) w_next = S_FILL;
   end

   // Row contents survive i_clear; only the count restarts, so stale rows are never used.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_rows <= '0;
         r_cnt  <= '0;
         r_col  <= '0;
         r_idx  <= '0;
         r_res  <= '0;
      end else if (bus.i_clear) begin
         r_cnt <= '0;
         r_col <= '0;
         r_idx <= '0;
      end else begin
         if (w_accept) begin
            for (int r = 0; r < K-1; r++) r_rows[r] <= r_rows[r+1];
            r_rows[K-1] <= bus.i_row;
            if (r_cnt != CNT_W'(K)) r_cnt <= r_cnt + 1'b1;
         end
         if (w_conv) r_col <= w_last_col ? '0 : r_col + 1'b1;
         if ((r_state == S_WAIT) && bus.i_conv_done) r_res <= bus.i_DataConv;
         if ((r_state == S_DRAIN) && bus.i_ready) r_idx <= w_last_idx ? '0 : r_idx + 1'b1;
      end
   end

   for (genvar j = 0; j < N; j++) begin : g_lane
      mcu_wseq_lane #(
         .J(j), .K(K), .NPIX(NPIX), .BI(BITS_IMAGEN), .COL_W(COL_W)
      ) u_lane (
         .i_rows (r_rows),
         .i_col  (r_col),
         .i_en   (w_conv),
         .o_col  (w_cols[j])
      );
   end
endmodule

// File: tb/tb_mcu_window_sequencer.sv
// Scoreboard bench: expected results queued when i_DataConv is driven,
// popped on each o_valid&i_ready handshake.
module tb_mcu_window_sequencer;
   localparam int N  = 4;
   localparam int K  = 3;
   localparam int BI = 8;
   localparam int BD = 13;
   localparam int RW = (N+K-1)*BI;
   localparam int DW = K*N*BI;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mcu_window_sequencer_if #(.N(N), .K(K), .BITS_IMAGEN(BI), .BITS_DATA(BD)) bus ();

   mcu_window_sequencer #(.N(N), .K(K), .BITS_IMAGEN(BI), .BITS_DATA(BD)) dut (
      .i_clock (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   int            total = 0;
   int            bad   = 0;
   logic [BD-1:0] sb[$];
   logic [BD-1:0] sb_exp;
   logic [RW-1:0] mrow[K];

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [RW-1:0] mkrow(input int r);
      logic [RW-1:0] v;
      v = '0;
      for (int p = 0; p < N+K-1; p++) v[p*BI +: BI] = {4'(r), 4'(p)};
      return v;
   endfunction

   function automatic logic [DW-1:0] exp_dc(input int col);
      logic [DW-1:0] v;
      v = '0;
      for (int j = 0; j < N; j++)
         for (int r = 0; r < K; r++)
            v[(j*K+r)*BI +: BI] = mrow[r][(j+col)*BI +: BI];
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outs(input string pfx);
      chk({pfx, "_row_ready"},  bus.o_row_ready, 1);
      chk({pfx, "_conv_valid"}, bus.o_conv_valid, 0);
      chk({pfx, "_conv_col"},   bus.o_conv_col, 0);
      chk({pfx, "_DataConv"},   bus.o_DataConv, 0);
      chk({pfx, "_o_valid"},    bus.o_valid, 0);
      chk({pfx, "_o_Data"},     bus.o_Data, 0);
   endtask

   // Leaves i_row_valid high; caller drops it.
   task automatic accept_row(input int r);
      bus.i_row = mkrow(r);
      bus.i_row_valid = 1'b1;
      #1;
      chk("row_ready_before_accept", bus.o_row_ready, 1);
      step();
      for (int i = 0; i < K-1; i++) mrow[i] = mrow[i+1];
      mrow[K-1] = mkrow(r);
   endtask

   task automatic run_conv(input int early_col, input bit unit1_chk);
      for (int c = 0; c < K; c++) begin
         chk("conv_valid", bus.o_conv_valid, 1);
         chk("conv_col", bus.o_conv_col, c);
         chk("row_ready_in_conv", bus.o_row_ready, 0);
         chk("DataConv", bus.o_DataConv, exp_dc(c));
         if (unit1_chk && c == 2) begin
            chk("u1_r0", bus.o_DataConv[(1*K+0)*BI +: BI], 8'h03);
            chk("u1_r1", bus.o_DataConv[(1*K+1)*BI +: BI], 8'h13);
            chk("u1_r2", bus.o_DataConv[(1*K+2)*BI +: BI], 8'h23);
         end
         if (c == early_col) begin
            bus.i_DataConv  = {13'h1AB, 13'h1AA, 13'h1A9, 13'h1A8};
            bus.i_conv_done = 1'b1;
         end
         step();
         bus.i_conv_done = 1'b0;
      end
      chk("conv_valid_end", bus.o_conv_valid, 0);
      chk("DataConv_idle", bus.o_DataConv, 0);
   endtask

   task automatic load_results(input int base);
      for (int j = 0; j < N; j++) bus.i_DataConv[j*BD +: BD] = BD'(base + j);
      bus.i_conv_done = 1'b1;
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.o_valid && bus.i_ready) begin
         if (sb.size() == 0) chk("spurious_handshake", 1, 0);
         else begin
            sb_exp = sb.pop_front();
            chk("o_Data", bus.o_Data, sb_exp);
         end
      end
   end

   initial begin
      bus.i_clear = 0; bus.i_row = '0; bus.i_row_valid = 0;
      bus.i_DataConv = '0; bus.i_conv_done = 0; bus.i_ready = 1;
      for (int i = 0; i < K; i++) mrow[i] = '0;
      #12;
      chk_reset_outs("rst");
      @(negedge clk) rst_n = 1'b1;
      step();

      // fill with valid held high throughout
      accept_row(0); chk("no_conv_1", bus.o_conv_valid, 0);
      accept_row(1); chk("no_conv_2", bus.o_conv_valid, 0);
      accept_row(2);
      bus.i_row = mkrow(9);
      run_conv(-1, 1'b1);
      bus.i_row_valid = 0;

      // results, no backpressure
      load_results(0);
      for (int j = 0; j < N; j++) sb.push_back(BD'(j));
      step();
      bus.i_conv_done = 0;
      for (int j = 0; j < N; j++) begin
         chk("drain_valid", bus.o_valid, 1);
         step();
      end
      chk("accept_row_ready", bus.o_row_ready, 1);
      chk("accept_o_valid", bus.o_valid, 0);

      // slide, early done during CONV
      accept_row(3);
      bus.i_row_valid = 0;
      chk("slide_u0_r0", bus.o_DataConv[0 +: BI], 8'h10);
      chk("slide_u0_r1", bus.o_DataConv[BI +: BI], 8'h20);
      chk("slide_u0_r2", bus.o_DataConv[2*BI +: BI], 8'h30);
      run_conv(1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("wait_no_valid", bus.o_valid, 0);
         step();
      end

      // backpressure at idx 1
      load_results(16'h10);
      for (int j = 0; j < N; j++) sb.push_back(BD'(16'h10 + j));
      step();
      bus.i_conv_done = 0;
      chk("bp_idx0_valid", bus.o_valid, 1);
      step();
      bus.i_ready = 0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold_valid", bus.o_valid, 1);
         chk("bp_hold_data", bus.o_Data, 13'h11);
         step();
      end
      bus.i_ready = 1;
      for (int i = 0; i < N-1; i++) begin
         chk("bp_rest_valid", bus.o_valid, 1);
         step();
      end
      chk("bp_accept", bus.o_row_ready, 1);

      // clear at idx 2 of drain
      accept_row(4);
      bus.i_row_valid = 0;
      run_conv(-1, 1'b0);
      load_results(16'h20);
      sb.push_back(13'h20);
      sb.push_back(13'h21);
      step();
      bus.i_conv_done = 0;
      step();
      step();
      chk("clr_idx2_data", bus.o_Data, 13'h22);
      bus.i_ready = 0;
      bus.i_clear = 1;
      #1;
      chk("clr_row_ready_forced", bus.o_row_ready, 0);
      step();
      bus.i_clear = 0;
      bus.i_ready = 1;
      #1;
      chk("clr_o_valid", bus.o_valid, 0);
      chk("clr_fill_ready", bus.o_row_ready, 1);
      chk("clr_conv_valid", bus.o_conv_valid, 0);

      // row offered with clear is refused
      bus.i_row = mkrow(5);
      bus.i_row_valid = 1;
      bus.i_clear = 1;
      #1;
      chk("clr_refuse_row", bus.o_row_ready, 0);
      step();
      bus.i_clear = 0;
      bus.i_row_valid = 0;
      accept_row(6); chk("refill_no_conv_1", bus.o_conv_valid, 0);
      accept_row(7); chk("refill_no_conv_2", bus.o_conv_valid, 0);
      accept_row(8);
      bus.i_row_valid = 0;
      chk("refill_conv", bus.o_conv_valid, 1);
      chk("refill_DataConv", bus.o_DataConv, exp_dc(0));
      step();
      chk("mid_conv_col1", bus.o_conv_col, 1);

      // async reset mid-CONV
      rst_n = 0;
      #1;
      chk_reset_outs("async_rst");
      @(negedge clk) rst_n = 1;
      step();
      chk_reset_outs("post_rst");
      chk("sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mcu_window_sequencer.md
# mcu_window_sequencer

Sequenced, parametrised successor to the MCU's combinational mux array. It buffers a sliding window of K image rows and presents, to N convolution units, one K-pixel column per unit per cycle over K cycles. It then collects the N convolution results and serialises them onto a valid/ready output stream. It sits in the MCU between the row memory and the convolution array, and its internal FSM replaces the external state, substate and memSelect selects.

## Interface
- N, 4, number of convolution units (any value ≥ 1)
- K, 3, kernel size (rows in window and columns stepped per window)
- BITS_IMAGEN, 8, pixel width
- BITS_DATA, 13, convolution result width
- i_clock  in  1  single clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_clear  in  1  synchronous frame restart
- i_row  in  (N+K-1)*BITS_IMAGEN  row slice; pixel p is at [p*BITS_IMAGEN +: BITS_IMAGEN]
- i_row_valid  in  1  i_row holds a valid row
- o_row_ready  out  1  block accepts a row this cycle
- o_DataConv  out  K*N*BITS_IMAGEN  window column per unit
- o_conv_valid  out  1  o_DataConv valid
- o_conv_col  out  clog2(K)  current column phase, 0..K-1
- i_DataConv  in  N*BITS_DATA  unit j result at [j*BITS_DATA +: BITS_DATA]
- i_conv_done  in  1  results on i_DataConv are valid
- o_Data  out  BITS_DATA  serialised result
- o_valid  out  1  o_Data valid
- i_ready  in  1  downstream accepts o_Data

## Operation
- Storage:
  - K row registers, row 0 oldest and row K-1 newest.
  - An accepted row shifts row r ← row r+1 and loads row K-1 ← i_row.
  - Row count saturates at K.
- FSM states:
  - FILL: o_row_ready=1. Each i_row_valid accepts a row. When the accept brings the row count to K, go to CONV.
  - CONV: lasts K cycles. o_conv_valid=1 and o_conv_col counts 0..K-1. After col K-1, go to WAIT.
  - WAIT: on i_conv_done, capture all N results into a result register and go to DRAIN. i_conv_done is ignored in every other state.
  - DRAIN:
    - o_valid=1 and o_Data = result[idx], where idx starts at 0.
    - Each o_valid&i_ready handshake increments idx.
    - The handshake at idx=N-1 goes to ACCEPT with idx reset to 0.
    - With i_ready low, o_Data and o_valid hold stable.
  - ACCEPT: o_row_ready=1. One accepted row shifts the window, then go to CONV.
- Window mapping, active during CONV only (o_DataConv is all zeros otherwise):
  - Unit j, row r slice [(j*K+r)*BITS_IMAGEN +: BITS_IMAGEN] = row r pixel (j + o_conv_col).
- i_clear:
  - Overrides all other inputs.
  - Next state is FILL, with row count, column counter and idx cleared and o_valid=0.
  - A row offered in the same cycle is not accepted: o_row_ready is forced low while i_clear=1.
- Outputs:
  - o_row_ready, o_conv_valid, o_conv_col and o_valid decode from registered state and counters.
  - o_row_ready is also gated by i_clear.

## Timing
- Reset (i_reset=0, asynchronous):
  - State FILL, row count 0, counters 0, result register 0.
  - Outputs: o_row_ready=1, o_conv_valid=0, o_conv_col=0, o_DataConv=0, o_valid=0, o_Data=0.
- Accept occurs at the clock edge where o_row_ready & i_row_valid.
- The K-th accepted row at edge t gives o_conv_valid=1 in the cycle after t, lasting exactly K cycles.
- i_conv_done in the first WAIT cycle gives o_valid=1 in the next cycle, so the minimum WAIT length is 1 cycle.
- Drain takes N cycles minimum, at one result per handshake.
- Steady-state window period with no stalls is 1 (ACCEPT) + K + 1 + N cycles.
- Reset mid-operation aborts immediately, and any partial drain is lost.
- i_clear during DRAIN drops the remaining results with no further o_valid.

## Test plan
- Fill:
  - Stimulus: reset, then 3 rows with pixel p of row r = {r[3:0],p[3:0]}, i_row_valid held high.
  - Required response:
    - o_row_ready drops after the 3rd accept.
    - o_conv_valid is high for 3 cycles.
    - At o_conv_col=2, unit 1 slices are 0x03, 0x13, 0x23.
- Results:
  - Stimulus: i_DataConv = {13'h3,13'h2,13'h1,13'h0} with i_conv_done pulsed in WAIT, i_ready=1.
  - Required response: o_Data sequence 0,1,2,3 on 4 consecutive o_valid cycles, then o_row_ready=1.
- Backpressure:
  - Stimulus: i_ready low for 5 cycles at idx=1.
  - Required response: o_Data=1 and o_valid=1 held stable, then 2 and 3 follow.
- Early done:
  - Stimulus: i_conv_done pulsed during CONV.
  - Required response: ignored, the FSM stays in WAIT until the next pulse, and no o_valid appears early.
- Slide:
  - Stimulus: in ACCEPT, a 4th row (r=3) is offered.
  - Required response: the next CONV shows unit 0 at col 0 as 0x10, 0x20, 0x30.
- Clear and reset:
  - Stimulus: i_clear at idx=2 of a drain; separately, i_reset low during CONV col 1.
  - Required response:
    - For i_clear: o_valid=0 next cycle, state FILL, and 3 new rows are required before CONV.
    - For i_reset: all outputs return to their reset values immediately.
